// File: rtl/test_mbox_ctrl.sv
// test_mbox_ctrl: sequencer and arbiter for the test device's shared message
// buffer. It sits in front of a single-port synchronous 2 KiB byte RAM. The
// lower half of the RAM holds the host's input string and the upper half holds
// the CPU's output string. The block runs the host start / CPU ack / CPU done
// exchange, raises the CPU interrupt, and round-robin arbitrates RAM cycles
// between the host and the CPU.
//
// Optional build macro: TEST_MBOX_TIMEOUT_EN. When it is defined, a response
// counter forces the exchange to DONE and sets h_timeout if the CPU takes too
// long. When it is not defined, no counter is built and h_timeout reads 0.

module test_mbox_ctrl #(
   parameter int AW      = 11,
   parameter int TIMEOUT = 400000,
   parameter int TW      = 20
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          h_start,
   input  logic          h_req,
   input  logic          h_we,
   input  logic [AW-1:0] h_addr,
   input  logic [7:0]    h_wdata,
   output logic          h_gnt,
   output logic          h_rvalid,
   output logic          h_busy,
   output logic          h_done,
   output logic          h_timeout,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW:0]   c_addr,
   input  logic [7:0]    c_wdata,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [7:0]    c_rdata,
   output logic          irq,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_wdata,
   input  logic [7:0]    ram_rdata
);

   typedef enum logic [1:0] {IDLE, PEND, RUN, DONE} state_t;

   state_t     state_q, state_d;
   logic       lastHost_q, lastHost_d;
   logic       hRvalid_q, hRvalid_d;
   logic       cRvalid_q, cRvalid_d;
   logic       cRegRd_q, cRegRd_d;
   logic [7:0] cRegData_q, cRegData_d;

   logic       regSel, ctrlWr, ackW, doneW, startEvt, expire;
   logic       cRamReq, hGnt, cRamGnt, writeProtect;
   logic       statPend, statRun;
   logic [7:0] statusVal;

   // Register space is selected by the CPU address MSB and never touches the
   // RAM. Only offset 1 (CTRL) is writable. DONE overrides ACK because the
   // next-state logic tests DONE first.
   assign regSel   = c_req & c_addr[AW];
   assign ctrlWr   = regSel & c_we & (c_addr[AW-1:0] == AW'(1));
   assign ackW     = ctrlWr & c_wdata[0];
   assign doneW    = ctrlWr & c_wdata[1];
   assign startEvt = h_start & ((state_q == IDLE) || (state_q == DONE));

`ifdef TEST_MBOX_TIMEOUT_EN
   logic [TW-1:0] cnt_q, cnt_d;
   logic          timedOut_q, timedOut_d;

   assign expire    = ((state_q == PEND) || (state_q == RUN)) &&
                      (cnt_q == TW'(TIMEOUT - 1));
   assign h_timeout = timedOut_q;

   // The response counter restarts on every accepted start and runs while an
   // exchange is open. The timeout flag is cleared only by the next start.
   always_comb begin
      cnt_d      = cnt_q;
      timedOut_d = timedOut_q;
      if (startEvt) begin
         cnt_d      = '0;
         timedOut_d = 1'b0;
      end else if ((state_q == PEND) || (state_q == RUN)) begin
         cnt_d = cnt_q + TW'(1);
         if (expire && !doneW) begin
            timedOut_d = 1'b1;
         end
      end
   end

   // Counter and timeout flag registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q      <= '0;
         timedOut_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         timedOut_q <= timedOut_d;
      end
   end
`else
   logic unusedParams;

   assign expire       = 1'b0;
   assign h_timeout    = 1'b0;
   assign unusedParams = ^TW'(TIMEOUT);
`endif

   // Exchange state register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Exchange next-state: DONE from the CPU beats a timeout, and a timeout
   // beats a late ACK
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (startEvt) state_d = PEND;
         PEND: begin
            if (doneW)       state_d = DONE;
            else if (expire) state_d = DONE;
            else if (ackW)   state_d = RUN;
         end
         RUN:  if (doneW || expire) state_d = DONE;
         DONE: if (startEvt) state_d = PEND;
         default: state_d = IDLE;
      endcase
   end

   // Exchange outputs are pure functions of the state
   always_comb begin
      statPend  = (state_q == PEND);
      statRun   = (state_q == RUN);
      h_busy    = statPend | statRun;
      h_done    = (state_q == DONE);
      irq       = statPend;
      statusVal = {4'b0000, h_timeout, h_done, statRun, statPend};
   end

   // Round-robin RAM arbitration. The requester that did not win the last
   // contended cycle wins now. Host writes into the input region are granted
   // but turned into no-ops while an exchange is open.
   always_comb begin
      cRamReq      = c_req & ~c_addr[AW];
      hGnt         = h_req & (~cRamReq | ~lastHost_q);
      cRamGnt      = cRamReq & (~h_req | lastHost_q);
      lastHost_d   = (h_req & cRamReq) ? hGnt : lastHost_q;
      writeProtect = h_busy & ~h_addr[AW-1];
      ram_en       = hGnt | cRamGnt;
      ram_we       = 1'b0;
      ram_addr     = h_addr;
      ram_wdata    = h_wdata;
      if (cRamGnt) begin
         ram_we    = c_we;
         ram_addr  = c_addr[AW-1:0];
         ram_wdata = c_wdata;
      end else if (hGnt) begin
         ram_we    = h_we & ~writeProtect;
      end
   end

   assign h_gnt = hGnt;
   assign c_gnt = regSel | cRamGnt;

   // Read completion tracking. Register reads capture STATUS in the request
   // cycle so the returned value matches the state seen at the request.
   always_comb begin
      hRvalid_d  = hGnt & ~h_we;
      cRvalid_d  = c_gnt & ~c_we;
      cRegRd_d   = regSel & ~c_we;
      cRegData_d = (c_addr[AW-1:0] == AW'(0)) ? statusVal : 8'h00;
   end

   // Read-valid, register read data and arbitration pointer registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         hRvalid_q  <= 1'b0;
         cRvalid_q  <= 1'b0;
         cRegRd_q   <= 1'b0;
         cRegData_q <= 8'h00;
         lastHost_q <= 1'b1;
      end else begin
         hRvalid_q  <= hRvalid_d;
         cRvalid_q  <= cRvalid_d;
         cRegRd_q   <= cRegRd_d;
         cRegData_q <= cRegData_d;
         lastHost_q <= lastHost_d;
      end
   end

   assign h_rvalid = hRvalid_q;
   assign c_rvalid = cRvalid_q;
   assign c_rdata  = cRegRd_q ? cRegData_q : ram_rdata;

endmodule

// File: tb/tb_test_mbox_ctrl.sv
// tb_test_mbox_ctrl: directed bench for test_mbox_ctrl with a behavioural
// single-port synchronous byte RAM. The timeout section is built only when
// TEST_MBOX_TIMEOUT_EN is defined. In that case the DUT runs with TIMEOUT=100.

module tb_test_mbox_ctrl;

   localparam int AW = 11;

   logic          clk = 1'b0;
   logic          rstn;
   logic          h_start, h_req, h_we;
   logic [AW-1:0] h_addr;
   logic [7:0]    h_wdata;
   logic          h_gnt, h_rvalid, h_busy, h_done, h_timeout;
   logic          c_req, c_we;
   logic [AW:0]   c_addr;
   logic [7:0]    c_wdata;
   logic          c_gnt, c_rvalid;
   logic [7:0]    c_rdata;
   logic          irq;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_wdata;
   logic [7:0]    ram_rdata = 8'h00;

   logic [7:0]    mem [0:2047];

   int assertCount = 0;
   int failCount   = 0;

   test_mbox_ctrl #(.AW(AW), .TIMEOUT(100), .TW(20)) dut (
      .clk(clk), .rstn(rstn),
      .h_start(h_start), .h_req(h_req), .h_we(h_we), .h_addr(h_addr),
      .h_wdata(h_wdata), .h_gnt(h_gnt), .h_rvalid(h_rvalid),
      .h_busy(h_busy), .h_done(h_done), .h_timeout(h_timeout),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .irq(irq),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: read data appears one cycle after the address
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         ram_rdata <= mem[ram_addr];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic hReq, input logic hWe,
                                input logic [AW-1:0] hAddr, input logic [7:0] hWdata,
                                input logic cReq, input logic cWe,
                                input logic [AW:0] cAddr, input logic [7:0] cWdata);
      h_req   = hReq;
      h_we    = hWe;
      h_addr  = hAddr;
      h_wdata = hWdata;
      c_req   = cReq;
      c_we    = cWe;
      c_addr  = cAddr;
      c_wdata = cWdata;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic cpuAccess(input logic we, input logic [AW:0] addr, input logic [7:0] data);
      applyStimulus(1'b0, 1'b0, '0, 8'h00, 1'b1, we, addr, data);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
   endtask

   task automatic hostAccess(input logic we, input logic [AW-1:0] addr, input logic [7:0] data);
      applyStimulus(1'b1, we, addr, data, 1'b0, 1'b0, '0, 8'h00);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
   endtask

   task automatic pulseStart;
      h_start = 1'b1;
      tick();
      h_start = 1'b0;
   endtask

   task automatic checkStatus(input string tag, input logic [7:0] expected);
      cpuAccess(1'b0, 12'h800, 8'h00);
      checkOutput({tag, "_rvalid"}, 8'(c_rvalid), 8'h01);
      checkOutput(tag, c_rdata, expected);
   endtask

   // Directed sequence: reset, contention, stray control, full exchange with
   // protection, DONE in PEND, reset mid-RUN, and the optional timeout
   initial begin
      rstn    = 1'b0;
      h_start = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
      tick();
      tick();
      checkOutput("rst_busy",     8'(h_busy),    8'h00);
      checkOutput("rst_done",     8'(h_done),    8'h00);
      checkOutput("rst_timeout",  8'(h_timeout), 8'h00);
      checkOutput("rst_irq",      8'(irq),       8'h00);
      checkOutput("rst_h_rvalid", 8'(h_rvalid),  8'h00);
      checkOutput("rst_c_rvalid", 8'(c_rvalid),  8'h00);

      $display("[TB] contention after reset");
      rstn = 1'b1;
      applyStimulus(1'b1, 1'b0, 11'h000, 8'h00, 1'b1, 1'b0, 12'h001, 8'h00);
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput("arb_gnt_hc", 8'({h_gnt, c_gnt}), (i % 2 == 0) ? 8'h01 : 8'h02);
         tick();
      end
      applyStimulus(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
      checkOutput("arb_h_rvalid", 8'(h_rvalid), 8'h01);
      checkOutput("arb_c_rvalid", 8'(c_rvalid), 8'h00);

      $display("[TB] stray ACK in IDLE");
      cpuAccess(1'b1, 12'h801, 8'h01);
      checkOutput("idle_ack_irq", 8'(irq), 8'h00);
      checkStatus("idle_ack_status", 8'h00);

      $display("[TB] basic exchange");
      hostAccess(1'b1, 11'h000, 8'h32);
      hostAccess(1'b1, 11'h001, 8'h2B);
      hostAccess(1'b1, 11'h002, 8'h32);
      hostAccess(1'b1, 11'h003, 8'h00);
      hostAccess(1'b1, 11'h005, 8'h77);
      pulseStart();
      checkOutput("start_irq",  8'(irq),    8'h01);
      checkOutput("start_busy", 8'(h_busy), 8'h01);
      checkStatus("pend_status", 8'h01);
      cpuAccess(1'b1, 12'h801, 8'h01);
      checkOutput("ack_irq",  8'(irq),    8'h00);
      checkOutput("ack_busy", 8'(h_busy), 8'h01);
      checkStatus("run_status", 8'h02);
      cpuAccess(1'b0, 12'h000, 8'h00);
      checkOutput("cpu_rd_in", c_rdata, 8'h32);
      cpuAccess(1'b1, 12'h400, 8'h34);
      cpuAccess(1'b1, 12'h401, 8'h00);

      $display("[TB] host write protection in RUN");
      applyStimulus(1'b1, 1'b1, 11'h005, 8'h41, 1'b0, 1'b0, '0, 8'h00);
      #1;
      checkOutput("prot_gnt",    8'(h_gnt),  8'h01);
      checkOutput("prot_ram_we", 8'(ram_we), 8'h00);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
      cpuAccess(1'b0, 12'h005, 8'h00);
      checkOutput("prot_old_val", c_rdata, 8'h77);
      applyStimulus(1'b1, 1'b1, 11'h405, 8'h55, 1'b0, 1'b0, '0, 8'h00);
      #1;
      checkOutput("out_ram_we", 8'(ram_we), 8'h01);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
      cpuAccess(1'b0, 12'h405, 8'h00);
      checkOutput("out_wr_val", c_rdata, 8'h55);

      $display("[TB] stray start in RUN");
      pulseStart();
      checkOutput("run_start_irq", 8'(irq), 8'h00);
      checkStatus("run_start_status", 8'h02);

      cpuAccess(1'b1, 12'h801, 8'h02);
      checkOutput("done_h_done", 8'(h_done), 8'h01);
      checkOutput("done_busy",   8'(h_busy), 8'h00);
      checkOutput("done_irq",    8'(irq),    8'h00);
      hostAccess(1'b0, 11'h400, 8'h00);
      checkOutput("host_rd_valid", 8'(h_rvalid), 8'h01);
      checkOutput("host_rd_data",  ram_rdata,    8'h34);
      checkStatus("done_status", 8'h04);
      cpuAccess(1'b1, 12'h801, 8'h01);
      checkStatus("done_ack_status", 8'h04);
      cpuAccess(1'b0, 12'h802, 8'h00);
      checkOutput("undef_rd", c_rdata, 8'h00);

      $display("[TB] DONE in PEND with both bits");
      pulseStart();
      checkOutput("pend2_irq", 8'(irq), 8'h01);
      cpuAccess(1'b1, 12'h803, 8'h03);
      checkOutput("undef_wr_irq", 8'(irq), 8'h01);
      cpuAccess(1'b1, 12'h801, 8'h03);
      checkOutput("pend_done_irq",  8'(irq),    8'h00);
      checkOutput("pend_done_busy", 8'(h_busy), 8'h00);
      checkStatus("pend_done_status", 8'h04);

      $display("[TB] reset mid-RUN");
      pulseStart();
      cpuAccess(1'b1, 12'h801, 8'h01);
      checkOutput("run2_busy", 8'(h_busy), 8'h01);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      checkOutput("mid_rst_busy", 8'(h_busy), 8'h00);
      checkOutput("mid_rst_irq",  8'(irq),    8'h00);
      checkOutput("mid_rst_done", 8'(h_done), 8'h00);
      checkStatus("mid_rst_status", 8'h00);
      pulseStart();
      checkOutput("post_rst_irq", 8'(irq), 8'h01);
      cpuAccess(1'b1, 12'h801, 8'h02);
      checkOutput("post_rst_done", 8'(h_done), 8'h01);

`ifdef TEST_MBOX_TIMEOUT_EN
      $display("[TB] timeout with TIMEOUT=100");
      pulseStart();
      checkOutput("to_start_irq", 8'(irq), 8'h01);
      repeat (99) tick();
      checkOutput("to_early_done", 8'(h_done), 8'h00);
      checkOutput("to_early_irq",  8'(irq),    8'h01);
      tick();
      checkOutput("to_done",    8'(h_done),    8'h01);
      checkOutput("to_timeout", 8'(h_timeout), 8'h01);
      checkOutput("to_irq",     8'(irq),       8'h00);
      checkOutput("to_busy",    8'(h_busy),    8'h00);
      checkStatus("to_status", 8'h0C);
      cpuAccess(1'b1, 12'h801, 8'h02);
      checkStatus("to_late_done_status", 8'h0C);
      pulseStart();
      checkOutput("to_clear_timeout", 8'(h_timeout), 8'h00);
      checkOutput("to_clear_irq",     8'(irq),       8'h01);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/test_mbox_ctrl.md
Name: test_mbox_ctrl

Overview:
- Sequencer and arbiter for the test device's shared message buffer.
- Sits between the host-side test interface and the CPU data bus, in front of one external single-port synchronous 2 KiB byte RAM.
  - RAM bytes 0x000-0x3FF: input string region.
  - RAM bytes 0x400-0x7FF: output string region.
- Runs the request/acknowledge/done exchange and raises the CPU interrupt.
- Round-robin arbitrates RAM cycles between host and CPU.
- Flags a response that takes too long.

Parameters:
- AW, 11, RAM byte address width.
- TIMEOUT, 400000, cycles allowed from host start to CPU done.
- TW, 20, timeout counter width; TIMEOUT < 2^TW.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rstn  in  1  synchronous active-low reset, sampled on posedge clk.
- h_start  in  1  one-cycle pulse: input region holds a new request.
- h_req  in  1  host RAM access request.
- h_we  in  1  host write enable.
- h_addr  in  AW  host byte address.
- h_wdata  in  8  host write data.
- h_gnt  out  1  host access accepted this cycle.
- h_rvalid  out  1  host read data valid on ram_rdata.
- h_busy  out  1  exchange in progress.
- h_done  out  1  response ready.
- h_timeout  out  1  last exchange timed out.
- c_req  in  1  CPU access request.
- c_we  in  1  CPU write enable.
- c_addr  in  AW+1  CPU address; MSB=1 selects the register space.
- c_wdata  in  8  CPU write data.
- c_gnt  out  1  CPU access accepted this cycle.
- c_rvalid  out  1  CPU read data valid.
- c_rdata  out  8  CPU read data: RAM data or register data.
- irq  out  1  level interrupt to the CPU.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, one cycle after the address.

Behaviour:
- Reset:
  - State goes to IDLE.
  - Outputs h_busy, h_done, h_timeout, irq, h_rvalid, c_rvalid go to 0.
  - Timeout counter goes to 0.
  - Round-robin pointer goes to "host last".
  - Reset mid-exchange abandons it; any RAM write granted in that same cycle still completes.
- FSM states: IDLE, PEND, RUN, DONE.
  - IDLE/DONE + h_start -> PEND. Clears h_done and h_timeout, sets irq and h_busy, zeroes the counter.
  - PEND + CPU write CTRL.ACK -> RUN. Clears irq.
  - PEND/RUN + CPU write CTRL.DONE -> DONE. Sets h_done and clears h_busy and irq. DONE in PEND is legal and skips RUN.
  - h_start in PEND/RUN is ignored.
  - ACK outside PEND is ignored; DONE outside PEND/RUN is ignored.
- Register space (c_addr MSB=1). It never uses the RAM and is granted in the same cycle it is requested.
  - Offset 0, STATUS, read: bit0 = PEND, bit1 = RUN, bit2 = h_done, bit3 = h_timeout, other bits 0.
  - Offset 1, CTRL, write: bit0 = ACK, bit1 = DONE. If both are set in one write, DONE wins.
  - Register reads return c_rvalid one cycle after the request, with STATUS sampled at the request cycle.
  - Writes to undefined offsets are ignored; reads of undefined offsets return 0.
- RAM arbitration:
  - Grants are combinational in the request cycle and are issued only when ram_en is free.
  - A single RAM requester wins.
  - When both request, the one not granted last wins; the pointer updates only on contended grants.
  - The loser keeps its request asserted and is granted next cycle at the latest.
  - ram_* is driven from the winner.
  - Reads complete the next cycle: h_rvalid or c_rvalid is 1 and c_rdata = ram_rdata.
  - Host write protection: host writes to 0x000-0x3FF while in PEND/RUN are granted but suppressed (ram_we=0).
  - Host reads are always allowed. CPU access is never restricted.
- h_busy = (state is PEND or RUN).

Optional Feature:
- Macro: TEST_MBOX_TIMEOUT_EN.
- Defined:
  - The counter increments every cycle in PEND/RUN.
  - When it reaches TIMEOUT-1 without DONE, the FSM goes to DONE with h_done=1, h_timeout=1 and irq=0.
  - A CPU DONE in that same cycle wins, with h_timeout=0.
  - CPU ACK/DONE arriving later are ignored.
- Undefined:
  - No counter is built and h_timeout is tied to 0.
  - STATUS bit3 reads 0.

Test Plan:
- Basic exchange: host writes "2+2\0" at 0x000, pulses h_start -> irq=1 next cycle, h_busy=1. CPU writes CTRL=0x01 -> irq=0, STATUS=0x02. CPU writes "4\0" at 0x400, then CTRL=0x02 -> h_done=1, h_busy=0. Host reads 0x400 -> '4' (0x34).
- Contention: h_req and c_req held together for 4 cycles -> grants alternate C,H,C,H after reset. The loser is granted in the next cycle.
- Protection: host write 0x41 to 0x005 during RUN -> h_gnt=1, ram_we=0, CPU read of 0x005 returns the old value. A host write to 0x405 in RUN succeeds.
- Timeout (macro on, TIMEOUT=100): h_start with no CPU response -> h_done=1 and h_timeout=1 exactly 100 cycles after PEND entry. A later CTRL=0x02 leaves STATUS unchanged.
- Reset mid-RUN: rstn=0 for one cycle -> all outputs 0, state IDLE. A new h_start then gives a normal irq.
- Stray control: CTRL=0x01 in IDLE -> no change. h_start during RUN -> ignored, irq stays 0.
